// File: rtl/in_cpld_pkg.sv
// Shared types and defaults for the input-concentrator CPLD reader.
// Frame width, frame type and the SPI read FSM state encoding.
package in_cpld_pkg;

    localparam int IN_FRAME_BITS = 75;
    localparam int IN_CLK_DIV    = 8;
    localparam int IN_CS_SETUP   = 5;
    localparam int IN_CS_HOLD    = 5;
    localparam int IN_POLL_GAP   = 500;

    typedef logic [0:IN_FRAME_BITS-1] in_frame_t;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_rd_state_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/in_cpld_spi_reader_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// Both stages clear to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Resample the async input twice to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/in_cpld_spi_reader.sv
// SPI master polling the input CPLD for its interlock frame.
// A frame is published as stable only after two identical reads.
module in_cpld_spi_reader
    import in_cpld_pkg::*;
#(
    parameter int FRAME_BITS = IN_FRAME_BITS,
    parameter int CLK_DIV    = IN_CLK_DIV,
    parameter int CS_SETUP   = IN_CS_SETUP,
    parameter int CS_HOLD    = IN_CS_HOLD,
    parameter int POLL_GAP   = IN_POLL_GAP
) (
    input  logic                  pclk_50M,
    input  logic                  rst_n,
    input  logic                  poll_en,
    output logic                  spi_cs,
    output logic                  spi_clk,
    input  logic                  miso,
    output logic                  busy,
    output logic [0:FRAME_BITS-1] frame_raw,
    output logic                  raw_valid,
    output logic [0:FRAME_BITS-1] frame_stable,
    output logic                  stable_valid,
    output logic                  stable_ok
);

    localparam int CNT_MAX = max_i(
        max_i(POLL_GAP, 2 * CLK_DIV),
        max_i(CS_SETUP, CS_HOLD));
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam int BIT_W = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(POLL_GAP - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    spi_rd_state_t state_q, state_d;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  clk_q, clk_d;
    logic                  cs_q, cs_d;
    logic [0:FRAME_BITS-1] shift_q, shift_d;
    logic [0:FRAME_BITS-1] raw_q, raw_d;
    logic                  rawv_q, rawv_d;
    logic                  prev_q, prev_d;
    logic                  match_q, match_d;
    logic [0:FRAME_BITS-1] stab_q, stab_d;
    logic                  stabv_q, stabv_d;
    logic                  ok_q, ok_d;
    logic                  miso_s;

    sync2 u_sync (
        .clk   (pclk_50M),
        .rst_n (rst_n),
        .d_i   (miso),
        .q_o   (miso_s)
    );

    // Next-state: bus sequencing, bit capture and debounce
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        clk_d   = clk_q;
        shift_d = shift_q;
        raw_d   = raw_q;
        rawv_d  = 1'b0;
        prev_d  = prev_q;
        match_d = 1'b0;
        stab_d  = stab_q;
        stabv_d = 1'b0;
        ok_d    = ok_q;

        // Publish one cycle after a raw frame that matched its predecessor
        if (rawv_q && match_q) begin
            stab_d  = raw_q;
            stabv_d = 1'b1;
            ok_d    = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (poll_en) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = HALF_LD;
                    bit_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!clk_q) begin
                    clk_d = 1'b1;
                    cnt_d = HALF_LD;
                end else begin
                    // Last high cycle: capture, then drop spi_clk
                    clk_d          = 1'b0;
                    shift_d[bit_q] = miso_s;
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        cnt_d = HALF_LD;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                    raw_d   = shift_q;
                    rawv_d  = 1'b1;
                    prev_d  = 1'b1;
                    match_d = prev_q && (shift_q == raw_q);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (poll_en) begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                clk_d   = 1'b0;
            end
        endcase

        cs_d = !((state_d == SETUP) ||
                 (state_d == SHIFT) ||
                 (state_d == HOLD));
    end

    // State and output registers; reset abandons any frame
    always_ff @(posedge pclk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            clk_q   <= 1'b0;
            cs_q    <= 1'b1;
            shift_q <= '0;
            raw_q   <= '0;
            rawv_q  <= 1'b0;
            prev_q  <= 1'b0;
            match_q <= 1'b0;
            stab_q  <= '0;
            stabv_q <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            clk_q   <= clk_d;
            cs_q    <= cs_d;
            shift_q <= shift_d;
            raw_q   <= raw_d;
            rawv_q  <= rawv_d;
            prev_q  <= prev_d;
            match_q <= match_d;
            stab_q  <= stab_d;
            stabv_q <= stabv_d;
            ok_q    <= ok_d;
        end
    end

    assign spi_cs       = cs_q;
    assign spi_clk      = clk_q;
    assign busy         = ~cs_q;
    assign frame_raw    = raw_q;
    assign raw_valid    = rawv_q;
    assign frame_stable = stab_q;
    assign stable_valid = stabv_q;
    assign stable_ok    = ok_q;

endmodule

// File: tb/tb_in_cpld_spi_reader.sv
// Directed bench for in_cpld_spi_reader with a CPLD slave model.
// A second instance at CLK_DIV=4 must read the same data.
module tb_in_cpld_spi_reader;
    import in_cpld_pkg::*;

    localparam int FB = IN_FRAME_BITS;
    localparam in_frame_t DATA =
        {3'b010, 72'hDA5F03C961E87B4C51};
    localparam in_frame_t ONES = '1;
    localparam in_frame_t ZERO = '0;

    logic pclk_50M = 1'b0;
    logic rst_n    = 1'b0;
    logic poll_en  = 1'b0;

    logic      spi_cs, spi_clk, miso, busy;
    in_frame_t frame_raw, frame_stable;
    logic      raw_valid, stable_valid, stable_ok;

    logic      spi_cs_v, spi_clk_v, miso_v, busy_v;
    in_frame_t frame_raw_v, frame_stable_v;
    logic      raw_valid_v, stable_valid_v, stable_ok_v;

    in_frame_t data_in = DATA;
    in_frame_t flip;
    in_frame_t sh, sh_v;
    logic      stuck = 1'b0;

    int nvec = 0;
    int nerr = 0;

    logic pcs, pck, seen_fall;
    int   cs_run, ck_run, rises, rises_last;
    int   cs_hi_last, cs_lo_last;
    int   hi_min, hi_max, lo_min, lo_max;

    in_cpld_spi_reader u_dut (
        .pclk_50M     (pclk_50M),
        .rst_n        (rst_n),
        .poll_en      (poll_en),
        .spi_cs       (spi_cs),
        .spi_clk      (spi_clk),
        .miso         (miso),
        .busy         (busy),
        .frame_raw    (frame_raw),
        .raw_valid    (raw_valid),
        .frame_stable (frame_stable),
        .stable_valid (stable_valid),
        .stable_ok    (stable_ok)
    );

    in_cpld_spi_reader #(.CLK_DIV(4)) u_dut4 (
        .pclk_50M     (pclk_50M),
        .rst_n        (rst_n),
        .poll_en      (poll_en),
        .spi_cs       (spi_cs_v),
        .spi_clk      (spi_clk_v),
        .miso         (miso_v),
        .busy         (busy_v),
        .frame_raw    (frame_raw_v),
        .raw_valid    (raw_valid_v),
        .frame_stable (frame_stable_v),
        .stable_valid (stable_valid_v),
        .stable_ok    (stable_ok_v)
    );

    always #10 pclk_50M = ~pclk_50M;

    initial begin
        miso   = 1'b0;
        miso_v = 1'b0;
    end

    // Slave model: load on cs fall, next bit on each clk fall
    always @(negedge spi_cs) begin
        sh   <= data_in;
        miso <= stuck | data_in[0];
    end
    always @(negedge spi_clk) begin
        if (!spi_cs) begin
            sh   <= {sh[1:FB-1], 1'b0};
            miso <= stuck | sh[1];
        end
    end
    always @(negedge spi_cs_v) begin
        sh_v   <= data_in;
        miso_v <= stuck | data_in[0];
    end
    always @(negedge spi_clk_v) begin
        if (!spi_cs_v) begin
            sh_v   <= {sh_v[1:FB-1], 1'b0};
            miso_v <= stuck | sh_v[1];
        end
    end

    // Bus timing monitor for the default instance
    always @(posedge pclk_50M) begin
        if (!rst_n) begin
            pcs        <= 1'b1;
            pck        <= 1'b0;
            seen_fall  <= 1'b0;
            cs_run     <= 0;
            ck_run     <= 0;
            rises      <= 0;
            rises_last <= 0;
            cs_hi_last <= 0;
            cs_lo_last <= 0;
            hi_min     <= 1000;
            hi_max     <= 0;
            lo_min     <= 1000;
            lo_max     <= 0;
        end else begin
            pcs <= spi_cs;
            pck <= spi_clk;
            if (spi_cs != pcs) begin
                if (pcs) begin
                    cs_hi_last <= cs_run;
                end else begin
                    cs_lo_last <= cs_run;
                    rises_last <= rises;
                end
                cs_run    <= 1;
                rises     <= 0;
                seen_fall <= 1'b0;
            end else begin
                cs_run <= cs_run + 1;
            end
            if (!spi_cs && spi_clk != pck) begin
                ck_run <= 1;
                if (pck) begin
                    seen_fall <= 1'b1;
                    if (ck_run < hi_min) hi_min <= ck_run;
                    if (ck_run > hi_max) hi_max <= ck_run;
                end else begin
                    rises <= rises + 1;
                    if (seen_fall) begin
                        if (ck_run < lo_min) lo_min <= ck_run;
                        if (ck_run > lo_max) lo_max <= ck_run;
                    end
                end
            end else begin
                ck_run <= ck_run + 1;
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, obs, exp);
        end
    endtask

    task automatic wait_raw(input int lim, output int n);
        n = 0;
        do begin
            @(negedge pclk_50M);
            n++;
        end while (!raw_valid && n < lim);
        if (!raw_valid) n = -1;
    endtask

    task automatic wait_bit(input int b);
        int k;
        k = 0;
        do begin
            @(negedge pclk_50M);
            k++;
        end while (!(!spi_cs && rises >= b) && k < 3000);
        chk("bit_reach", 32'(rises), 32'(b));
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lows;
        flip     = DATA;
        flip[74] = ~flip[74];

        repeat (3) @(negedge pclk_50M);
        rst_n = 1'b1;
        repeat (3) @(negedge pclk_50M);
        chk("rst_cs", spi_cs, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_raw", frame_raw, ZERO);
        chk("rst_ok", stable_ok, 1'b0);

        // First frame: latency, data, not published
        poll_en = 1'b1;
        wait_raw(3000, n);
        chk("lat1", n, 1211);
        chk("raw1", frame_raw, DATA);
        @(negedge pclk_50M);
        chk("sv1", stable_valid, 1'b0);
        chk("ok1", stable_ok, 1'b0);

        // Second identical frame publishes
        wait_raw(3000, n);
        chk("raw2_seen", raw_valid, 1'b1);
        @(negedge pclk_50M);
        chk("sv2", stable_valid, 1'b1);
        chk("stab2", frame_stable, DATA);
        chk("ok2", stable_ok, 1'b1);
        chk("v4_stab", frame_stable_v, DATA);
        chk("v4_raw", frame_raw_v, DATA);

        // Last bit flipped for a single frame
        data_in = flip;
        wait_raw(3000, n);
        chk("raw3_seen", raw_valid, 1'b1);
        chk("raw3", frame_raw, flip);
        data_in = DATA;
        @(negedge pclk_50M);
        chk("sv3", stable_valid, 1'b0);
        chk("stab3", frame_stable, DATA);

        // Bus timing of the frame just finished
        chk("cs_low", 32'(cs_lo_last), 32'd1210);
        chk("cs_gap", 32'(cs_hi_last), 32'd500);
        chk("rises", 32'(rises_last), 32'd75);
        chk("hi_min", 32'(hi_min), 32'd8);
        chk("hi_max", 32'(hi_max), 32'd8);
        chk("lo_min", 32'(lo_min), 32'd8);
        chk("lo_max", 32'(lo_max), 32'd8);

        wait_raw(3000, n);
        chk("raw4_seen", raw_valid, 1'b1);
        @(negedge pclk_50M);
        chk("sv4", stable_valid, 1'b0);
        wait_raw(3000, n);
        chk("raw5_seen", raw_valid, 1'b1);
        @(negedge pclk_50M);
        chk("sv5", stable_valid, 1'b1);
        chk("stab5", frame_stable, DATA);

        // Stop request mid-frame
        wait_bit(30);
        poll_en = 1'b0;
        wait_raw(3000, n);
        chk("raw6_seen", raw_valid, 1'b1);
        chk("raw6", frame_raw, DATA);
        lows = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge pclk_50M);
            if (!spi_cs) lows++;
        end
        chk("idle_lows", lows, 0);
        chk("idle_cs", spi_cs, 1'b1);
        chk("idle_busy", busy, 1'b0);
        poll_en = 1'b1;
        @(negedge pclk_50M);
        chk("idle_exit", spi_cs, 1'b0);

        // Reset mid-frame
        wait_bit(40);
        rst_n = 1'b0;
        #1;
        chk("mr_cs", spi_cs, 1'b1);
        chk("mr_clk", spi_clk, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_raw", frame_raw, ZERO);
        chk("mr_stab", frame_stable, ZERO);
        chk("mr_pulse", {raw_valid, stable_valid}, 2'b00);
        chk("mr_ok", stable_ok, 1'b0);
        chk("mr_v4", {spi_cs_v, spi_clk_v, busy_v,
                      raw_valid_v, stable_valid_v,
                      stable_ok_v}, 6'b100000);
        chk("mr_v4f", {frame_raw_v, frame_stable_v},
            150'd0);
        repeat (2) @(negedge pclk_50M);
        rst_n = 1'b1;
        wait_raw(3000, n);
        chk("lat8", n, 1211);
        chk("raw8", frame_raw, DATA);
        @(negedge pclk_50M);
        chk("sv8", stable_valid, 1'b0);
        chk("ok8", stable_ok, 1'b0);
        wait_raw(3000, n);
        chk("raw9_seen", raw_valid, 1'b1);
        @(negedge pclk_50M);
        chk("ok9", stable_ok, 1'b1);

        // miso stuck high on both instances
        rst_n = 1'b0;
        stuck = 1'b1;
        repeat (2) @(negedge pclk_50M);
        rst_n = 1'b1;
        wait_raw(3000, n);
        chk("raw10_seen", raw_valid, 1'b1);
        chk("raw10", frame_raw, ONES);
        @(negedge pclk_50M);
        chk("sv10", stable_valid, 1'b0);
        wait_raw(3000, n);
        chk("raw11_seen", raw_valid, 1'b1);
        @(negedge pclk_50M);
        chk("sv11", stable_valid, 1'b1);
        chk("stab11", frame_stable, ONES);
        chk("v4_ones", frame_stable_v, ONES);
        chk("v4_ok", stable_ok_v, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

endmodule
